// File: rtl/ni_link_arbiter.sv
// Round-robin arbiter that shares one router injection link between NUM_PORTS NI FIFOs.
// A winner is popped, its flit is registered, and it is held on out_* until the router takes it.
module ni_link_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 64,
   parameter int SRC_W      = 2,
   parameter int MAX_BURST  = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            req_empty,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
   output logic [NUM_PORTS-1:0]            req_rd_en,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [SRC_W-1:0]                out_src,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            busy
);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   typedef enum logic [1:0] {IDLE, POP, WAIT, SEND} state_t;

   state_t                 state, state_nxt;
   logic [SRC_W-1:0]       grant, grant_nxt;
   logic [SRC_W-1:0]       rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]       burst_cnt, burst_cnt_nxt;
   logic [DATA_WIDTH-1:0]  out_data_nxt;
   logic [SRC_W-1:0]       out_src_nxt;
   logic                   out_valid_nxt;
   logic [SRC_W-1:0]       winner;
   logic                   any_req;

   // First non-empty port at or above rr_ptr, wrapping past the last port.
   always_comb begin : win_search
      int idx;
      idx     = 0;
      winner  = '0;
      any_req = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!any_req && !req_empty[idx]) begin
            winner  = SRC_W'(idx);
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      out_data_nxt  = out_data;
      out_src_nxt   = out_src;
      out_valid_nxt = out_valid;
      case (state)
         IDLE: begin
            if (any_req) begin
               grant_nxt = winner;
               state_nxt = POP;
            end
         end
         POP: state_nxt = WAIT;
         WAIT: begin
            out_data_nxt  = req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            out_src_nxt   = grant;
            out_valid_nxt = 1'b1;
            state_nxt     = SEND;
         end
         SEND: begin
            if (out_ready) begin
               out_valid_nxt = 1'b0;
               // Empty flag is re-sampled here, so a burst never pops a drained FIFO.
               if ((int'(burst_cnt) + 1 < MAX_BURST) && !req_empty[grant]) begin
                  burst_cnt_nxt = burst_cnt + CNT_W'(1);
                  state_nxt     = POP;
               end else begin
                  burst_cnt_nxt = '0;
                  rr_ptr_nxt    = (int'(grant) == NUM_PORTS-1) ? '0 : SRC_W'(int'(grant) + 1);
                  state_nxt     = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         out_data  <= '0;
         out_src   <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         rr_ptr    <= rr_ptr_nxt;
         burst_cnt <= burst_cnt_nxt;
         out_data  <= out_data_nxt;
         out_src   <= out_src_nxt;
         out_valid <= out_valid_nxt;
      end
   end

   // Pop strobe depends only on registered state, never on the inputs.
   always_comb begin
      req_rd_en = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         req_rd_en[i] = (state == POP) && (int'(grant) == i);
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_ni_link_arbiter.sv
// Randomized bench for ni_link_arbiter: FIFO models feed the DUT and a queue-based
// scheduler model predicts every flit (source and payload) the router should receive.
module tb_ni_link_arbiter;
   localparam int N  = 4;
   localparam int DW = 64;
   localparam int SW = 2;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_empty;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_rd_en;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;
   logic            out_valid;
   logic            out_ready;
   logic            busy;

   always #5 clk = ~clk;

   ni_link_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .SRC_W(SW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset), .req_empty(req_empty), .req_data(req_data),
      .req_rd_en(req_rd_en), .out_data(out_data), .out_src(out_src),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   logic [DW-1:0] fq[N][$];
   logic [DW-1:0] dout[N];
   int            exp_src[$];
   logic [DW-1:0] exp_dat[$];
   int            m_rr;
   int            checks, failures;
   int            cyc;
   int            ready_pct, stall_left, hs_cnt;
   int            pop_cnt[N];
   logic [N-1:0]  s_rd;
   logic          s_valid, s_ready, s_busy;
   logic [DW-1:0] s_data, p_data;
   logic [SW-1:0] s_src, p_src;
   logic          p_stall;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive_fifo_pins;
      for (int i = 0; i < N; i++) begin
         req_empty[i]          = (fq[i].size() == 0);
         req_data[i*DW +: DW]  = dout[i];
      end
   endtask

   task automatic load(input int port, input logic [DW-1:0] d);
      fq[port].push_back(d);
   endtask

   // Scheduler model: serve first non-empty port from m_rr, up to MB flits, then rotate.
   task automatic plan;
      int pos[N];
      int w, n;
      for (int i = 0; i < N; i++) pos[i] = 0;
      forever begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && pos[(m_rr + k) % N] < fq[(m_rr + k) % N].size()) w = (m_rr + k) % N;
         if (w < 0) break;
         n = 0;
         while (n < MB && pos[w] < fq[w].size()) begin
            exp_src.push_back(w);
            exp_dat.push_back(fq[w][pos[w]]);
            pos[w]++;
            n++;
         end
         m_rr = (w + 1) % N;
      end
   endtask

   task automatic step;
      @(negedge clk);
      s_rd = req_rd_en; s_valid = out_valid; s_ready = out_ready; s_busy = busy;
      s_data = out_data; s_src = out_src;
      if (p_stall) begin
         chk("stall_valid", 64'(s_valid), 64'd1);
         chk("stall_data", s_data, p_data);
         chk("stall_src", 64'(s_src), 64'(p_src));
      end
      if (s_rd != '0) chk("rd_onehot", 64'($onehot(s_rd)), 64'd1);
      for (int i = 0; i < N; i++)
         if (s_rd[i]) begin
            chk("pop_nonempty", 64'(fq[i].size() != 0), 64'd1);
            pop_cnt[i]++;
         end
      if (s_valid && s_ready) begin
         hs_cnt++;
         if (exp_src.size() == 0) chk("unexpected_flit", 64'd1, 64'd0);
         else begin
            chk("flit_src", 64'(s_src), 64'(exp_src.pop_front()));
            chk("flit_data", s_data, exp_dat.pop_front());
         end
      end
      p_stall = s_valid && !s_ready;
      p_data  = s_data;
      p_src   = s_src;
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++)
         if (s_rd[i] && fq[i].size() > 0) dout[i] = fq[i].pop_front();
      drive_fifo_pins();
      if (stall_left > 0) begin
         out_ready = 1'b0;
         if (out_valid) stall_left--;
      end else begin
         out_ready = ($urandom_range(99) < ready_pct);
      end
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while ((exp_src.size() > 0 || busy) && t < 3000) begin
         step();
         t++;
      end
      chk({tag, "_timeout"}, 64'(t < 3000), 64'd1);
      chk({tag, "_all_sent"}, 64'(exp_src.size()), 64'd0);
      for (int i = 0; i < N; i++) chk({tag, "_fifo_empty"}, 64'(fq[i].size()), 64'd0);
   endtask

   task automatic clear_model;
      for (int i = 0; i < N; i++) begin
         fq[i].delete();
         dout[i] = '0;
      end
      exp_src.delete();
      exp_dat.delete();
      m_rr = 0;
      stall_left = 0;
      p_stall = 1'b0;
      drive_fifo_pins();
   endtask

   initial begin
      int load_cyc, first_rd, first_val, hs0, pc0[N], tmo;
      logic [N-1:0] rd_seen;
      checks = 0; failures = 0; cyc = 0; hs_cnt = 0;
      ready_pct = 100;
      for (int i = 0; i < N; i++) pop_cnt[i] = 0;
      reset = 1'b1;
      out_ready = 1'b0;
      clear_model();
      #12;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_rd_en", 64'(req_rd_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_src", 64'(out_src), 64'd0);
      step(); step();
      reset = 1'b0;

      // Idle with every FIFO empty.
      for (int k = 0; k < 20; k++) begin
         step();
         if (k % 5 == 0) begin
            chk("idle_valid", 64'(s_valid), 64'd0);
            chk("idle_rd_en", 64'(s_rd), 64'd0);
            chk("idle_busy", 64'(s_busy), 64'd0);
         end
      end

      // Single flit on port 2 with 10 stalled cycles, then latency and pulse count.
      stall_left = 10;
      hs0 = hs_cnt;
      for (int i = 0; i < N; i++) pc0[i] = pop_cnt[i];
      load(2, 64'h0000_0010_DEAD_BEEF);
      plan();
      drive_fifo_pins();
      load_cyc = cyc; first_rd = -1; first_val = -1; tmo = 0;
      while (hs_cnt == hs0 && tmo < 100) begin
         step();
         tmo++;
         if (first_rd < 0 && s_rd != '0) begin
            first_rd = cyc - 1 - load_cyc;
            chk("single_rd_pattern", 64'(s_rd), 64'b0100);
         end
         if (first_val < 0 && s_valid) first_val = cyc - 1 - load_cyc;
      end
      chk("single_timeout", 64'(tmo < 100), 64'd1);
      chk("single_rd_latency", 64'(first_rd), 64'd1);
      chk("single_valid_latency", 64'(first_val), 64'd3);
      drain("single");
      chk("single_hs_count", 64'(hs_cnt - hs0), 64'd1);
      chk("single_pop_count", 64'(pop_cnt[2] - pc0[2]), 64'd1);

      // Wrap-around: pointer now sits at 3, so port 3 precedes port 0.
      load(0, {$urandom, $urandom});
      load(3, {$urandom, $urandom});
      plan();
      drive_fifo_pins();
      drain("wrap");

      // Fresh reset, one flit per port: service order 0,1,2,3.
      reset = 1'b1;
      #2;
      reset = 1'b0;
      clear_model();
      for (int i = 0; i < N; i++) pc0[i] = pop_cnt[i];
      for (int i = 0; i < N; i++) load(i, {$urandom, $urandom});
      plan();
      drive_fifo_pins();
      drain("rr");
      for (int i = 0; i < N; i++) chk("rr_one_pop", 64'(pop_cnt[i] - pc0[i]), 64'd1);

      // Burst limit: port 1 holds 6, port 3 holds 1.
      for (int k = 0; k < 6; k++) load(1, {$urandom, $urandom});
      load(3, {$urandom, $urandom});
      plan();
      drive_fifo_pins();
      drain("burst");

      // Random loads with random backpressure.
      for (int r = 0; r < 20; r++) begin
         ready_pct = $urandom_range(100, 30);
         for (int i = 0; i < N; i++) begin
            int cnt;
            cnt = $urandom_range(7);
            for (int k = 0; k < cnt; k++) load(i, {$urandom, $urandom});
         end
         plan();
         drive_fifo_pins();
         drain("rand");
      end

      // Reset while a flit is stalled in SEND; arbitration must restart from port 0.
      ready_pct = 100;
      load(1, {$urandom, $urandom});
      plan();
      drive_fifo_pins();
      drain("pre_rst");
      for (int k = 0; k < 3; k++) load(2, {$urandom, $urandom});
      plan();
      drive_fifo_pins();
      stall_left = 1000;
      tmo = 0;
      s_valid = 1'b0;
      while (!s_valid && tmo < 50) begin
         step();
         tmo++;
      end
      chk("midrst_reach_send", 64'(s_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_rd_en", 64'(req_rd_en), 64'd0);
      clear_model();
      step();
      step();
      reset = 1'b0;
      rd_seen = '0;
      load(3, {$urandom, $urandom});
      load(0, {$urandom, $urandom});
      plan();
      drive_fifo_pins();
      drain("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
